// File: rtl/video_composite_timing.sv
// Composite video timing sequencer: line/field counters with NTSC equalizing, serrated vsync,
// burst gate, active window and pixel coordinates. Every output is registered from counter state.
module video_composite_timing #(
   parameter int H_TOTAL     = 1588,
   parameter int H_SYNC      = 117,
   parameter int H_EQ        = 58,
   parameter int H_BURST_ST  = 133,
   parameter int H_BURST_LEN = 63,
   parameter int H_ACT_ST    = 242,
   parameter int H_ACT_LEN   = 1280,
   parameter int V_ACT_ST    = 21,
   parameter int V_ACT_LEN   = 240
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        interlace,
   output logic        sync_n_in,
   output logic        color_burst,
   output logic        active,
   output logic        field,
   output logic [10:0] x,
   output logic [8:0]  y,
   output logic        vblank_pulse
);

   localparam logic [10:0] HLAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] HHALF   = 11'(H_TOTAL / 2);
   localparam logic [10:0] HSYNC   = 11'(H_SYNC);
   localparam logic [10:0] HEQ     = 11'(H_EQ);
   localparam logic [10:0] HEQ2_ST = 11'(H_TOTAL / 2);
   localparam logic [10:0] HEQ2_END = 11'(H_TOTAL / 2 + H_EQ);
   localparam logic [10:0] HSER1   = 11'(H_TOTAL / 2 - H_SYNC);
   localparam logic [10:0] HSER2   = 11'(H_TOTAL - H_SYNC);
   localparam logic [10:0] HB_ST   = 11'(H_BURST_ST);
   localparam logic [10:0] HB_END  = 11'(H_BURST_ST + H_BURST_LEN);
   localparam logic [10:0] HA_ST   = 11'(H_ACT_ST);
   localparam logic [10:0] HA_END  = 11'(H_ACT_ST + H_ACT_LEN);
   localparam logic [8:0]  VA_ST   = 9'(V_ACT_ST);
   localparam logic [8:0]  VA_END  = 9'(V_ACT_ST + V_ACT_LEN);

   typedef enum logic [2:0] {EQ_PRE, VSYNC, EQ_POST, BLANK, PICTURE} line_t;

   logic [10:0] hcnt;
   logic [8:0]  vcnt;
   logic        field_q;
   line_t       line_state;

   logic [10:0] phase;
   line_t       vi_line;
   logic        sync_low;
   logic        burst_on;
   logic        act_on;
   logic [8:0]  vmax;

   function automatic line_t line_kind(input logic [8:0] v);
      if (v < 9'd3)                      return EQ_PRE;
      else if (v < 9'd6)                 return VSYNC;
      else if (v < 9'd9)                 return EQ_POST;
      else if (v >= VA_ST && v < VA_END) return PICTURE;
      else                               return BLANK;
   endfunction

   // The odd field runs its vertical-interval pulse train half a line late, so the pulse
   // shape is taken from the line that started h2 clocks ago and its phase within it.
   always_comb begin
      phase   = hcnt;
      vi_line = line_state;
      if (field_q) begin
         if (hcnt >= HHALF) begin
            phase = hcnt - HHALF;
         end else begin
            phase   = hcnt + HHALF;
            vi_line = line_kind(vcnt - 9'd1);
         end
      end

      case (vi_line)
         EQ_PRE, EQ_POST: sync_low = (phase < HEQ) || (phase >= HEQ2_ST && phase < HEQ2_END);
         VSYNC:           sync_low = !((phase >= HSER1 && phase < HHALF) || phase >= HSER2);
         default:         sync_low = hcnt < HSYNC;
      endcase

      burst_on = (hcnt >= HB_ST) && (hcnt < HB_END)
               && (line_state == BLANK || line_state == PICTURE)
               && (vi_line == BLANK || vi_line == PICTURE);
      act_on   = (line_state == PICTURE) && (hcnt >= HA_ST) && (hcnt < HA_END);
      vmax     = field_q ? 9'd262 : 9'd261;
   end

   // Counters, line FSM and registered outputs; disabling behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         hcnt         <= '0;
         vcnt         <= '0;
         field_q      <= 1'b0;
         line_state   <= EQ_PRE;
         sync_n_in    <= 1'b1;
         color_burst  <= 1'b0;
         active       <= 1'b0;
         field        <= 1'b0;
         x            <= '0;
         y            <= '0;
         vblank_pulse <= 1'b0;
      end else begin
         sync_n_in    <= !sync_low;
         color_burst  <= burst_on;
         active       <= act_on;
         field        <= field_q;
         x            <= act_on ? hcnt - HA_ST : '0;
         y            <= act_on ? vcnt - VA_ST : '0;
         vblank_pulse <= (vcnt == VA_END) && (hcnt == '0);

         if (hcnt == HLAST) begin
            hcnt <= '0;
            if (vcnt == vmax) begin
               vcnt       <= '0;
               field_q    <= interlace ? ~field_q : 1'b0;
               line_state <= EQ_PRE;
            end else begin
               vcnt       <= vcnt + 9'd1;
               line_state <= line_kind(vcnt + 9'd1);
            end
         end else begin
            hcnt <= hcnt + 11'd1;
         end
      end
   end

endmodule
